// File: rtl/mem_access_unit.sv
// ============================================================================
// mem_access_unit : unified instruction/data memory port for the multi-cycle
//                   MIPS datapath; owns IR and MDR and decodes IR fields.
// Revision        : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit #(
  parameter int BIT_WIDTH = 32,
  parameter int MAX_WAIT  = 15,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 IorD,
  input  logic                 MemWrite,
  input  logic                 IRWrite,
  input  logic [BIT_WIDTH-1:0] pc,
  input  logic [BIT_WIDTH-1:0] alu_out,
  input  logic [BIT_WIDTH-1:0] wdata,
  output logic                 m_req,
  output logic                 m_we,
  output logic [BIT_WIDTH-1:0] m_addr,
  output logic [BIT_WIDTH-1:0] m_wdata,
  input  logic [BIT_WIDTH-1:0] m_rdata,
  input  logic                 m_ack,
  output logic [BIT_WIDTH-1:0] instr,
  output logic [5:0]           Op,
  output logic [5:0]           Funct,
  output logic [4:0]           rs,
  output logic [4:0]           rt,
  output logic [4:0]           rd,
  output logic [4:0]           shamt,
  output logic [15:0]          imm,
  output logic [BIT_WIDTH-1:0] mdr,
  output logic                 busy,
  output logic                 done,
  output logic                 bus_err
);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_access = 2'd1;
  localparam logic [1:0] c_st_err    = 2'd2;

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(MAX_WAIT - 1);

  logic [1:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_m_req;
  logic                 r_m_we;
  logic                 r_ir_sel;
  logic [BIT_WIDTH-1:0] r_m_addr;
  logic [BIT_WIDTH-1:0] r_m_wdata;
  logic [BIT_WIDTH-1:0] r_instr;
  logic [BIT_WIDTH-1:0] r_mdr;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_bus_err;

  logic [BIT_WIDTH-1:0] w_sel_addr;

  assign w_sel_addr = IorD ? alu_out : pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_st_idle;
      r_cnt     <= '0;
      r_m_req   <= 1'b0;
      r_m_we    <= 1'b0;
      r_ir_sel  <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_instr   <= '0;
      r_mdr     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (req) begin
            // A misaligned address never reaches the bus; it faults at accept.
            if (w_sel_addr[1:0] != 2'b00) begin
              r_state   <= c_st_err;
              r_bus_err <= 1'b1;
            end else begin
              r_state   <= c_st_access;
              r_m_addr  <= w_sel_addr;
              r_m_we    <= MemWrite;
              r_m_wdata <= wdata;
              r_ir_sel  <= IRWrite & ~MemWrite;
              r_cnt     <= '0;
              r_m_req   <= 1'b1;
              r_busy    <= 1'b1;
            end
          end
        end
        c_st_access: begin
          if (m_ack) begin
            r_state <= c_st_idle;
            r_m_req <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            if (!r_m_we) begin
              if (r_ir_sel) r_instr <= m_rdata;
              else          r_mdr   <= m_rdata;
            end
          end else if (r_cnt == c_cnt_last) begin
            r_state   <= c_st_err;
            r_m_req   <= 1'b0;
            r_busy    <= 1'b0;
            r_bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_st_err: begin
          r_bus_err <= 1'b1;
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  assign m_req   = r_m_req;
  assign m_we    = r_m_we;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;
  assign instr   = r_instr;
  assign mdr     = r_mdr;
  assign busy    = r_busy;
  assign done    = r_done;
  assign bus_err = r_bus_err;

  assign Op    = r_instr[31:26];
  assign rs    = r_instr[25:21];
  assign rt    = r_instr[20:16];
  assign rd    = r_instr[15:11];
  assign shamt = r_instr[10:6];
  assign Funct = r_instr[5:0];
  assign imm   = r_instr[15:0];

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Unified instruction/data memory interface for the multi-cycle MIPS datapath.
- Sits between the control unit's memory strobes (IorD, MemWrite, IRWrite) and a single external memory port with variable-latency ack.
- Owns the Instruction Register and Memory Data Register, and decodes IR fields (Op, Funct, rs, rt, rd, shamt, imm) back to the control unit.
- Reports completion, busy and bus errors so control-unit states can hold until the access finishes.

Parameters:
BIT_WIDTH, 32, data/address width
MAX_WAIT, 15, max ACCESS cycles without m_ack before timeout error
CNT_W, 4, wait-counter width (must hold MAX_WAIT)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
req  input  1  access request from control unit (level; sampled in IDLE only)
IorD  input  1  0 = address from pc, 1 = address from alu_out
MemWrite  input  1  1 = write access
IRWrite  input  1  1 = read data goes to IR, 0 = read data goes to MDR
pc  input  BIT_WIDTH  program counter
alu_out  input  BIT_WIDTH  registered ALU result (data address)
wdata  input  BIT_WIDTH  store data (rt value)
m_req  output  1  memory request, held until ack
m_we  output  1  memory write enable
m_addr  output  BIT_WIDTH  memory byte address
m_wdata  output  BIT_WIDTH  memory write data
m_rdata  input  BIT_WIDTH  memory read data, valid with m_ack
m_ack  input  1  memory acknowledge, one cycle
instr  output  BIT_WIDTH  Instruction Register
Op  output  6  instr[31:26]
Funct  output  6  instr[5:0]
rs, rt, rd, shamt  output  5 each  instr[25:21], [20:16], [15:11], [10:6]
imm  output  16  instr[15:0]
mdr  output  BIT_WIDTH  Memory Data Register
busy  output  1  high in ACCESS
done  output  1  one-cycle pulse after an access completes
bus_err  output  1  sticky error flag

Behaviour:
- Reset (rst=1, async): state=IDLE; m_req, m_we, done, bus_err, busy = 0; m_addr, m_wdata, instr, mdr, counter = 0.
- States: IDLE, ACCESS, ERR. All outputs are registered; busy = (state==ACCESS).
- IDLE, req=1 at edge N:
  - Latch m_addr = IorD ? alu_out : pc.
  - Latch m_we = MemWrite, m_wdata = wdata, ir_sel = IRWrite & ~MemWrite.
  - Clear the counter, set m_req=1, go to ACCESS. m_req is high in cycle N+1.
- Misaligned address (selected address[1:0] != 0) at accept: go to ERR, bus_err=1, m_req stays 0, no access issued.
- ACCESS:
  - m_req, m_we, m_addr and m_wdata stay stable.
  - m_ack=1: m_req=0, state=IDLE, done=1 for the next cycle only.
    - Read with ir_sel=1: instr <= m_rdata.
    - Read with ir_sel=0: mdr <= m_rdata.
    - Write: instr and mdr unchanged.
  - m_ack=0: counter++. When counter==MAX_WAIT-1 with no ack, go to ERR, m_req=0, bus_err=1.
- Latency: ack in cycle N+1+k (k>=0) means instr/mdr are updated at the end of that cycle and done is high in cycle N+2+k with the new data visible.
- ERR: absorbing; req is ignored and bus_err stays 1 until rst.
- req while busy: ignored, no queuing. Strobes are sampled only at accept.
- Back-to-back: req high in the done cycle (state IDLE) is accepted, so m_req rises the following cycle.
- m_ack while m_req=0 (IDLE/ERR): ignored, no register updates.
- instr and mdr hold their values indefinitely between accesses. Field outputs are combinational slices of instr.
- rst mid-ACCESS: m_req drops immediately (async) and all state clears.

Test Plan:
- Fetch: rst, pc=0x0040_0000, IorD=0, IRWrite=1, req; memory acks after 2 wait cycles with 0x3C01_1001 -> m_addr=0x0040_0000, m_we=0, done pulses 4 cycles after req, instr=0x3C01_1001, Op=15, rt=1, imm=0x1001, mdr unchanged.
- Load: IorD=1, alu_out=0x1001_0004, IRWrite=0, ack at k=0 with 0xDEAD_BEEF -> mdr=0xDEAD_BEEF, instr unchanged, done at N+2.
- Store: MemWrite=1, IRWrite=1, IorD=1, alu_out=0x1001_0008, wdata=0x0000_00AA -> m_we=1, m_wdata=0xAA held until ack; instr and mdr unchanged.
- Timeout: MAX_WAIT=15, never ack -> m_req high exactly 15 cycles, then bus_err=1; later req and m_ack ignored until rst.
- Misaligned: IorD=1, alu_out=0x1001_0002, req -> m_req never asserts, bus_err=1 next cycle.
- Reset mid-access: assert rst 1 cycle into ACCESS -> m_req=0 without waiting for clk, instr=0; after release a new fetch completes normally.
